// File: rtl/exec_hazard_ctrl_if.sv
// Purpose: pipeline-status and control-strobe bundle between the hazard controller and the pipeline.
// Latency: wires only, no storage.
// Backpressure: none; the hold/bubble/flush strobes carried here are the pipeline's stall mechanism.
//
// Ports (signals):
//   DECODE sources : id_src1_idx/id_src2_idx, id_src1_used/id_src2_used
//   EXECUTE        : ex_opcode, ex_dest_idx, ex_we, ex_branch_taken
//   MEM            : mem_dest_idx, mem_we, mem_req, mem_ready
//   control        : cnt_clr
//   strobes        : pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_bubble, pc_redirect
//   forwarding     : fwd_a, fwd_b (00 regfile, 01 EX result, 10 MEM result)
//   status         : fault, stall_cnt, flush_cnt
// Modports: master = hazard controller, slave = pipeline side.
interface exec_hazard_ctrl_if #(
   parameter int IDX_W = 6
);
   logic [IDX_W-1:0] id_src1_idx;
   logic [IDX_W-1:0] id_src2_idx;
   logic             id_src1_used;
   logic             id_src2_used;
   logic [3:0]       ex_opcode;
   logic [IDX_W-1:0] ex_dest_idx;
   logic             ex_we;
   logic             ex_branch_taken;
   logic [IDX_W-1:0] mem_dest_idx;
   logic             mem_we;
   logic             mem_req;
   logic             mem_ready;
   logic             cnt_clr;

   logic             pc_hold;
   logic             ifid_hold;
   logic             idex_hold;
   logic             exmem_hold;
   logic             ifid_flush;
   logic             idex_bubble;
   logic             pc_redirect;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic             fault;
   logic [15:0]      stall_cnt;
   logic [15:0]      flush_cnt;

   modport master (
      input  id_src1_idx, id_src2_idx, id_src1_used, id_src2_used,
             ex_opcode, ex_dest_idx, ex_we, ex_branch_taken,
             mem_dest_idx, mem_we, mem_req, mem_ready, cnt_clr,
      output pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush,
             idex_bubble, pc_redirect, fwd_a, fwd_b, fault, stall_cnt, flush_cnt
   );

   modport slave (
      output id_src1_idx, id_src2_idx, id_src1_used, id_src2_used,
             ex_opcode, ex_dest_idx, ex_we, ex_branch_taken,
             mem_dest_idx, mem_we, mem_req, mem_ready, cnt_clr,
      input  pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush,
             idex_bubble, pc_redirect, fwd_a, fwd_b, fault, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/exec_hazard_ctrl.sv
// Purpose: hazard/sequencing controller: holds, bubbles, flushes, redirects and operand forwarding.
// Latency: strobes and forwarding selects are combinational (0 cycles); fault and counters are registered.
// Backpressure: a not-ready memory access freezes the whole pipe; a timeout parks it in a sticky fault.
//
// Ports: clk, rst_n (async active-low), hz (exec_hazard_ctrl_if.master, see interface file for signals).
// Parameters: IDX_W register-index width, TIMEOUT_CYCLES (2..255) not-ready cycles before fault.
module exec_hazard_ctrl #(
   parameter int IDX_W          = 6,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   exec_hazard_ctrl_if.master hz
);

   localparam logic [3:0] OP_LOAD   = 4'b1100;
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;

   state_t      state;
   logic [7:0]  wait_cnt;
   logic        fault_q;
   logic [15:0] stall_q;
   logic [15:0] flush_q;

   logic ex_is_load;
   logic memstall;
   logic loaduse;
   logic run_eval;
   logic freeze;
   logic act_branch;
   logic act_loaduse;
   logic ex_fwd_ok;

   assign ex_is_load = (hz.ex_opcode == OP_LOAD);
   assign memstall   = hz.mem_req & ~hz.mem_ready;
   assign loaduse    = ex_is_load & hz.ex_we &
                       ((hz.id_src1_used & (hz.ex_dest_idx == hz.id_src1_idx)) |
                        (hz.id_src2_used & (hz.ex_dest_idx == hz.id_src2_idx)));

   // The ready cycle of a memory wait is evaluated like RUN so a pending
   // branch or load-use is acted on the moment the freeze releases.
   assign run_eval    = (state == RUN) | ((state == MEM_WAIT) & hz.mem_ready);
   assign freeze      = (state == FAULT) |
                        ((state == MEM_WAIT) & ~hz.mem_ready) |
                        (run_eval & memstall);
   assign act_branch  = run_eval & ~memstall & hz.ex_branch_taken;
   assign act_loaduse = run_eval & ~memstall & ~hz.ex_branch_taken & loaduse;

   assign hz.pc_hold     = freeze | act_loaduse;
   assign hz.ifid_hold   = freeze | act_loaduse;
   assign hz.idex_hold   = freeze;
   assign hz.exmem_hold  = freeze;
   assign hz.ifid_flush  = act_branch;
   assign hz.pc_redirect = act_branch;
   assign hz.idex_bubble = act_branch | act_loaduse;

   // A LOAD result is not available in EXECUTE, so it is never forwarded from there.
   assign ex_fwd_ok = hz.ex_we & ~ex_is_load;

   assign hz.fwd_a = (ex_fwd_ok & (hz.ex_dest_idx == hz.id_src1_idx))  ? 2'b01 :
                     (hz.mem_we & (hz.mem_dest_idx == hz.id_src1_idx)) ? 2'b10 : 2'b00;
   assign hz.fwd_b = (ex_fwd_ok & (hz.ex_dest_idx == hz.id_src2_idx))  ? 2'b01 :
                     (hz.mem_we & (hz.mem_dest_idx == hz.id_src2_idx)) ? 2'b10 : 2'b00;

   assign hz.fault     = fault_q;
   assign hz.stall_cnt = stall_q;
   assign hz.flush_cnt = flush_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         wait_cnt <= 8'd0;
         fault_q  <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (memstall) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= 8'd1;
               end
            end
            MEM_WAIT: begin
               if (hz.mem_ready) begin
                  state <= RUN;
               end else if (wait_cnt == WAIT_LAST) begin
                  state   <= FAULT;
                  fault_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            FAULT: begin
               fault_q <= 1'b1;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

   // Stall cycles spent parked in FAULT are not counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= 16'd0;
         flush_q <= 16'd0;
      end else if (hz.cnt_clr) begin
         stall_q <= 16'd0;
         flush_q <= 16'd0;
      end else begin
         if (hz.pc_hold && (state != FAULT) && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
         end
         if (hz.pc_redirect && (flush_q != 16'hFFFF)) begin
            flush_q <= flush_q + 16'd1;
         end
      end
   end

endmodule

// File: doc/exec_hazard_ctrl.md
# exec_hazard_ctrl

Pipeline sequencing controller for the 16-bit pipelined core. It watches the instructions in DECODE, EXECUTE and MEM and drives hold, bubble, flush and redirect strobes to the PC and pipeline registers. It also drives the operand-forwarding selects used by DECODE. A small state machine freezes the pipe during multi-cycle memory accesses, raises a sticky fault on memory timeout, and keeps saturating stall and flush counters.

## Interface
Parameters:
- IDX_W, 6, register-index width (matches the EXECUTE destination index).
- TIMEOUT_CYCLES, 64, consecutive not-ready memory cycles before fault; legal range 2..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_src1_idx, id_src2_idx  in  IDX_W  source indices of the instruction in DECODE.
- id_src1_used, id_src2_used  in  1  the source is actually read.
- ex_opcode  in  4  opcode in EXECUTE (LOAD = 4'b1100).
- ex_dest_idx  in  IDX_W  destination index in EXECUTE.
- ex_we  in  1  the EXECUTE instruction writes a register.
- ex_branch_taken  in  1  EXECUTE resolved a taken JUMP/JUMPx this cycle.
- mem_dest_idx  in  IDX_W  destination index in MEM.
- mem_we  in  1  the MEM instruction writes a register.
- mem_req  in  1  MEM stage has an active load/store.
- mem_ready  in  1  memory completes the access this cycle.
- cnt_clr  in  1  synchronous clear of both counters.
- pc_hold, ifid_hold, idex_hold, exmem_hold  out  1  hold the respective register.
- ifid_flush  out  1  overwrite IF/ID with NOP.
- idex_bubble  out  1  load NOP into ID/EX.
- pc_redirect  out  1  PC takes EXECUTE target.
- fwd_a, fwd_b  out  2  operand select: 00 = register file, 01 = EX result, 10 = MEM result.
- fault  out  1  sticky memory-timeout fault.
- stall_cnt, flush_cnt  out  16  saturating performance counters.

## Operation
- FSM states: RUN, MEM_WAIT, FAULT. Reset state is RUN.
- Events are evaluated combinationally every cycle in RUN:
  - memstall = mem_req & ~mem_ready.
  - branch = ex_branch_taken.
  - loaduse = ex_opcode==LOAD & ex_we & ((id_src1_used & ex_dest_idx==id_src1_idx) | (id_src2_used & ex_dest_idx==id_src2_idx)).
- Priority is memstall > branch > loaduse.
- memstall response: pc_hold, ifid_hold, idex_hold and exmem_hold are all 1. Next state is MEM_WAIT. A pending branch or load-use is not acted on and is re-evaluated once the freeze releases.
- branch response: pc_redirect=1, ifid_flush=1, idex_bubble=1. Any simultaneous load-use is discarded.
- loaduse response: pc_hold=1, ifid_hold=1, idex_bubble=1 for exactly one cycle. The bubble clears the condition on the next cycle.
- MEM_WAIT:
  - All four holds are 1 while mem_ready=0.
  - In the cycle mem_ready=1, the holds drop combinationally, normal RUN evaluation applies in that same cycle, and the next state is RUN.
- Timeout:
  - wait_cnt (8 bits) is set to 1 when MEM_WAIT is entered and increments every MEM_WAIT cycle with mem_ready=0.
  - When wait_cnt==TIMEOUT_CYCLES-1 and mem_ready=0, the next state is FAULT.
- FAULT:
  - All four holds are 1 and fault=1.
  - Flush, bubble and redirect are 0.
  - Only rst_n exits this state.
- Forwarding is combinational and independent of state:
  - fwd_a=01 if ex_we & ex_opcode!=LOAD & ex_dest_idx==id_src1_idx.
  - Otherwise fwd_a=10 if mem_we & mem_dest_idx==id_src1_idx.
  - Otherwise fwd_a=00.
  - fwd_b uses the same rule against id_src2_idx.
- Counters:
  - stall_cnt increments in every cycle with pc_hold=1 while not in FAULT.
  - flush_cnt increments in every cycle with pc_redirect=1.
  - Both saturate at 16'hFFFF.
  - cnt_clr has priority over increment and forces 0 on the next edge.

## Timing
- Reset values: state=RUN, wait_cnt=0, fault=0, stall_cnt=0, flush_cnt=0.
- With inputs idle during reset, all strobes are 0 and fwd_a=fwd_b=00.
- Strobes and forwarding selects have zero latency: they are combinational from inputs and current state.
- State, wait_cnt and the counters update on the rising edge of clk.
- fault is registered and asserts in the first FAULT cycle.
- Counter values reflect events up to and including the previous cycle.
- rst_n assertion mid-MEM_WAIT or in FAULT returns to RUN immediately and asynchronously clears all state.
- mem_req=1 with mem_ready=1 in RUN causes no freeze and no state change.

## Test plan
- Load-use: ex_opcode=1100, ex_we=1, ex_dest_idx=5, id_src2_idx=5, id_src2_used=1 -> exactly one cycle of pc_hold=ifid_hold=idex_bubble=1; stall_cnt 0->1.
- Forwarding: ex ADD dest 3 and mem dest 3 both writing, id_src1_idx=3 -> fwd_a=01. Same case with ex_opcode=LOAD -> fwd_a=10, and load-use stall asserted.
- Branch vs load-use: branch and loaduse in the same cycle -> pc_redirect=ifid_flush=idex_bubble=1, pc_hold=0; flush_cnt+1, stall_cnt unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 5 cycles then 1 -> all four holds high for 5 cycles and low in the ready cycle; stall_cnt+5; state back to RUN.
- Timeout: TIMEOUT_CYCLES=4, mem_ready held 0 -> fault=1 from the 5th cycle, holds stay high; rst_n pulse -> fault=0, counters 0.
- Saturation and clear: stall held long enough that stall_cnt reaches FFFF -> stays FFFF; cnt_clr=1 -> 0 next edge, even while stalling.
